vie_sram_resp: RTL and testbench

Single-port synchronous SRAM responder: the target side of the core's `*_sram_en/wen/addr/wdata/rdata` interface. It answers every access with fixed one-cycle read latency and byte-masked writes, and contains a small MMIO window (free-running timer, scratch register, write counter). The bench and FPGA top instantiate one per CPU port, inst and data, so the pipeline can run without external memory IP.

---
 rtl/vie_sram_resp_pkg.sv | 50 +++++
 rtl/vie_sram_array.sv | 34 +++
 rtl/vie_sram_resp.sv | 113 +++++++++++
 tb/tb_vie_sram_resp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vie_sram_resp_pkg.sv
// vie_sram_resp_pkg
//   Shared constants and helpers for the SRAM responder: the MMIO page and
//   register offsets, the read-source and register-select enums, and the
//   byte-merge helper used by every byte-writable register.
package vie_sram_resp_pkg;

  localparam logic [31:0] VIE_MMIO_BASE    = 32'hBFAF_0000;
  localparam logic [15:0] VIE_MMIO_PAGE    = VIE_MMIO_BASE[31:16];
  localparam logic [15:0] VIE_MMIO_TIMER   = 16'h0000;
  localparam logic [15:0] VIE_MMIO_SCRATCH = 16'h0004;
  localparam logic [15:0] VIE_MMIO_WRCNT   = 16'h0008;

  typedef enum logic [1:0] {
    REG_TIMER,
    REG_SCRATCH,
    REG_WRCNT,
    REG_NONE
  } mmio_reg_e;

  // Source of sram_rdata, chosen when an access is accepted.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_MMIO
  } rd_sel_e;

  // Byte-address offsets: the two low bits are masked off before comparing.
  function automatic mmio_reg_e decode_reg(input logic [15:0] off);
    logic [15:0] word_off;
    word_off = off & 16'hFFFC;
    case (word_off)
      VIE_MMIO_TIMER:   decode_reg = REG_TIMER;
      VIE_MMIO_SCRATCH: decode_reg = REG_SCRATCH;
      VIE_MMIO_WRCNT:   decode_reg = REG_WRCNT;
      default:          decode_reg = REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vie_sram_array.sv
// vie_sram_array
//   Byte-enabled single-port RAM, 2^ADDR_W x 32 bits, read-first output
//   register. No reset on the array or the output register so that the
//   tools can map it onto block RAM; contents survive a core reset.
// Ports:
//   clk    - clock
//   en     - access enable; the output register only loads when set
//   wen    - byte write mask (0 = read)
//   addr   - word index
//   wdata  - write data
//   rdata  - registered word contents from before the write
module vie_sram_array #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/vie_sram_resp.sv
// vie_sram_resp
//   Target side of the core's SRAM interface. Fixed one-cycle read latency,
//   byte-masked writes, read-first on every accepted access, no back-pressure.
//   A 64 KiB MMIO page holds a free-running TIMER, a SCRATCH register and a
//   saturating RAM-write counter WRCNT; everything else goes to the RAM array
//   with address wrap-around.
// Ports:
//   clk        - clock
//   resetn     - asynchronous active-low reset
//   sram_en    - access request
//   sram_wen   - byte write mask, 0 = read
//   sram_addr  - byte address (bits [1:0] ignored)
//   sram_wdata - write data
//   sram_rdata - registered read data
module vie_sram_resp
  import vie_sram_resp_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter bit MMIO_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata
);

  logic        mmio_hit;
  logic        ram_en;
  logic        ram_wr;
  logic        mmio_wr;
  mmio_reg_e   reg_sel;
  logic [31:0] mmio_rd;
  logic [31:0] ram_q;

  logic [31:0] timer_q;
  logic [31:0] scratch_q;
  logic [31:0] wrcnt_q;
  logic [31:0] mmio_q;
  rd_sel_e     sel_q;

  assign mmio_hit = MMIO_EN && (sram_addr[31:16] == VIE_MMIO_PAGE);
  assign ram_en   = sram_en && !mmio_hit;
  assign ram_wr   = ram_en && (sram_wen != 4'h0);
  assign mmio_wr  = sram_en && mmio_hit && (sram_wen != 4'h0);
  assign reg_sel  = decode_reg(sram_addr[15:0]);

  always_comb begin
    mmio_rd = 32'h0;
    case (reg_sel)
      REG_TIMER:   mmio_rd = timer_q;
      REG_SCRATCH: mmio_rd = scratch_q;
      REG_WRCNT:   mmio_rd = wrcnt_q;
      default:     mmio_rd = 32'h0;
    endcase
  end

  vie_sram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .wen   (sram_wen),
    .addr  (sram_addr[ADDR_W+1:2]),
    .wdata (sram_wdata),
    .rdata (ram_q)
  );

  // TIMER free-runs; a write that targets it replaces that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
      wrcnt_q   <= 32'h0;
    end else begin
      if (mmio_wr && reg_sel == REG_TIMER) timer_q <= byte_merge(timer_q, sram_wdata, sram_wen);
      else                                 timer_q <= timer_q + 32'd1;

      if (mmio_wr && reg_sel == REG_SCRATCH)
        scratch_q <= byte_merge(scratch_q, sram_wdata, sram_wen);

      if (ram_wr && wrcnt_q != 32'hFFFF_FFFF) wrcnt_q <= wrcnt_q + 32'd1;
    end
  end

  // The array's output register has no reset, so the read-source flag falls
  // back to SEL_ZERO on reset to force sram_rdata to 0 until the next access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mmio_q <= 32'h0;
      sel_q  <= SEL_ZERO;
    end else if (sram_en) begin
      if (mmio_hit) begin
        mmio_q <= mmio_rd;
        sel_q  <= SEL_MMIO;
      end else begin
        sel_q  <= SEL_RAM;
      end
    end
  end

  always_comb begin
    sram_rdata = 32'h0;
    case (sel_q)
      SEL_RAM:  sram_rdata = ram_q;
      SEL_MMIO: sram_rdata = mmio_q;
      default:  sram_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_vie_sram_resp.sv
module tb_vie_sram_resp;

  localparam int ADDR_W = 14;
  localparam logic [31:0] MM = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;

  int n_pass = 0;
  int n_total = 0;

  vie_sram_resp #(.ADDR_W(ADDR_W), .MMIO_EN(1'b1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] mem_m [int];
  logic [3:0]  kn_m  [int];
  logic [31:0] m_rdata, m_timer, m_scratch, m_wrcnt, t_next;
  logic        m_known;
  int          idx;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  initial begin
    m_rdata = 0; m_known = 0; m_timer = 0; m_scratch = 0; m_wrcnt = 0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_rdata = 0; m_known = 1; m_timer = 0; m_scratch = 0; m_wrcnt = 0;
      end else begin
        t_next = m_timer + 1;
        if (sram_en) begin
          if (sram_addr[31:16] == MM[31:16]) begin
            m_known = 1;
            case (sram_addr[15:2])
              14'd0: begin
                m_rdata = m_timer;
                if (sram_wen != 0) t_next = mrg(m_timer, sram_wdata, sram_wen);
              end
              14'd1: begin
                m_rdata = m_scratch;
                m_scratch = mrg(m_scratch, sram_wdata, sram_wen);
              end
              14'd2: m_rdata = m_wrcnt;
              default: m_rdata = 0;
            endcase
          end else begin
            idx = int'(sram_addr[ADDR_W+1:2]);
            if (!mem_m.exists(idx)) begin mem_m[idx] = 0; kn_m[idx] = 0; end
            m_rdata = mem_m[idx];
            m_known = (kn_m[idx] == 4'hF);
            if (sram_wen != 0) begin
              mem_m[idx] = mrg(mem_m[idx], sram_wdata, sram_wen);
              kn_m[idx] = kn_m[idx] | sram_wen;
              if (m_wrcnt != 32'hFFFF_FFFF) m_wrcnt = m_wrcnt + 1;
            end
          end
        end
        m_timer = t_next;
      end
    end
  end

  // Compare process: every cycle where the model knows the word.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) check("rdata_in_reset", sram_rdata, 32'h0);
      else if (m_known) check("rdata_model", sram_rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wd;
    @(posedge clk);
    #1;
    sram_en = 1'b0; sram_wen = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b1;
  endtask

  logic [31:0] r, a, wd;
  logic [15:0] off;
  logic [3:0]  wm;

  initial begin
    #1 resetn = 1'b0;
    #2 check("reset_rdata", sram_rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // TIMER counts the 10 idle edges since release.
    idle(10);
    access(1'b1, 4'h0, MM | 32'h0, 32'h0);
    check("timer_10", sram_rdata, 32'd10);

    // Full write / readback, write cycle returns old word.
    access(1'b1, 4'hF, 32'h10, 32'h0102_0304);
    access(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    check("write_returns_old", sram_rdata, 32'h0102_0304);
    access(1'b1, 4'h0, 32'h10, 32'h0);
    check("readback_deadbeef", sram_rdata, 32'hDEAD_BEEF);

    // Byte-masked merge.
    access(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    access(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    access(1'b1, 4'h0, 32'h20, 32'h0);
    check("byte_merge", sram_rdata, 32'h11BB_33DD);

    // Aliasing through upper address bits.
    access(1'b1, 4'hF, 32'h0, 32'h0000_0055);
    access(1'b1, 4'h0, 32'd4 << ADDR_W, 32'h0);
    check("alias", sram_rdata, 32'h0000_0055);

    // TIMER write wins, then wraps through 0.
    access(1'b1, 4'hF, MM | 32'h0, 32'hFFFF_FFFE);
    idle(3);
    access(1'b1, 4'h0, MM | 32'h0, 32'h0);
    check("timer_wrap", sram_rdata, 32'd1);

    // WRCNT: 5 RAM writes, 2 MMIO writes, 3 reads.
    pulse_reset();
    for (int i = 0; i < 5; i++) access(1'b1, 4'hF, 32'h100 + 32'(4*i), 32'h5000 + 32'(i));
    access(1'b1, 4'hF, MM | 32'h4, 32'h1234_5678);
    access(1'b1, 4'b0010, MM | 32'h4, 32'h0000_AB00);
    for (int i = 0; i < 3; i++) access(1'b1, 4'h0, 32'h100 + 32'(4*i), 32'h0);
    access(1'b1, 4'h0, MM | 32'h4, 32'h0);
    check("scratch_merge", sram_rdata, 32'h1234_AB78);
    access(1'b1, 4'h0, MM | 32'h8, 32'h0);
    check("wrcnt_5", sram_rdata, 32'd5);
    access(1'b1, 4'hF, MM | 32'h8, 32'hFFFF_0000);
    access(1'b1, 4'h0, MM | 32'h8, 32'h0);
    check("wrcnt_ro", sram_rdata, 32'd5);
    access(1'b1, 4'hF, MM | 32'h100, 32'hCAFE_F00D);
    access(1'b1, 4'h0, MM | 32'h100, 32'h0);
    check("mmio_hole", sram_rdata, 32'h0);

    // Reset in the middle of a read burst.
    access(1'b1, 4'h0, 32'h100, 32'h0);
    access(1'b1, 4'h0, 32'h104, 32'h0);
    sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h108;
    #2 resetn = 1'b0;
    #1;
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_timer", dut.timer_q, 32'h0);
    check("rst_scratch", dut.scratch_q, 32'h0);
    check("rst_wrcnt", dut.wrcnt_q, 32'h0);
    sram_en = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b1;
    access(1'b1, 4'h0, 32'h10, 32'h0);
    check("ram_survives_reset", sram_rdata, 32'hDEAD_BEEF);
    access(1'b1, 4'h0, MM | 32'h4, 32'h0);
    check("scratch_after_reset", sram_rdata, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 16; i++) access(1'b1, 4'hF, 32'(i) << 2, $urandom());
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom();
      wd = $urandom();
      wm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
      if ($urandom_range(0, 4) == 0) begin
        access(1'b0, wm, r, wd);
      end else if ($urandom_range(0, 9) < 7) begin
        a = {r[31:16], 14'($urandom_range(0, 15)), r[1:0]};
        if (a[31:16] == MM[31:16]) a[31:16] = 16'h0;
        access(1'b1, wm, a, wd);
      end else begin
        case ($urandom_range(0, 4))
          0: off = 16'h0000;
          1: off = 16'h0004;
          2: off = 16'h0008;
          3: off = 16'h0100;
          default: off = r[15:0];
        endcase
        off[1:0] = r[1:0];
        // Keep TIMER writes rare so reads see it counting.
        if (off[15:2] == 14'd0 && $urandom_range(0, 3) != 0) wm = 4'h0;
        access(1'b1, wm, {MM[31:16], off}, wd);
      end
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
